// File: rtl/mult32x32_ctrl.sv
// mult32x32_ctrl: start/busy/done sequencer for the 32x32 multiply datapath.
// It steps the 16x16 multiplier through the four partial products
// A_lo*B_lo, A_lo*B_hi<<16, A_hi*B_lo<<16 and A_hi*B_hi<<32 into the
// accumulating product register.
// The optional build macro MULT_SKIP_ZERO_EN skips any partial product whose
// selected A or B half is zero. A skipped term contributes 0, so the result
// does not change, but done arrives earlier.
// DONE_STICKY=1 holds done high after an operation until the next start is
// accepted or reset is asserted.
module mult32x32_ctrl #(
  parameter bit DONE_STICKY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  shift_sel,
  output logic        upd_prod,
  output logic        clr_prod
);

  localparam int unsigned STEP_N = 4;

  // Step masks: bit i is step i in schedule order P00, P01, P10, P11.
  localparam logic [STEP_N-1:0] AFTER_IDLE = 4'b1111;
  localparam logic [STEP_N-1:0] AFTER_P00  = 4'b1110;
  localparam logic [STEP_N-1:0] AFTER_P01  = 4'b1100;
  localparam logic [STEP_N-1:0] AFTER_P10  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P00  = 3'd1,
    S_P01  = 3'd2,
    S_P10  = 3'd3,
    S_P11  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              sticky_q;
  logic              sticky_nxt;
  logic [STEP_N-1:0] run_c;

`ifdef MULT_SKIP_ZERO_EN
  logic a_lo_nz_c;
  logic a_hi_nz_c;
  logic b_lo_nz_c;
  logic b_hi_nz_c;

  // A step runs only when both of its selected operand halves are non-zero.
  assign a_lo_nz_c = |a[15:0];
  assign a_hi_nz_c = |a[31:16];
  assign b_lo_nz_c = |b[15:0];
  assign b_hi_nz_c = |b[31:16];
  assign run_c     = {a_hi_nz_c & b_hi_nz_c, a_hi_nz_c & b_lo_nz_c,
                      a_lo_nz_c & b_hi_nz_c, a_lo_nz_c & b_lo_nz_c};
`else
  logic unused_ab;

  // Fixed schedule: every step runs, and the operand bus is not observed.
  assign run_c     = AFTER_IDLE;
  assign unused_ab = ^{a, b};
`endif

  // Select the earliest runnable step in schedule order. DONE is used when
  // no step is left.
  function automatic state_t first_step(input logic [STEP_N-1:0] mask);
    state_t s;
    s = S_DONE;
    if (mask[3]) s = S_P11;
    if (mask[2]) s = S_P10;
    if (mask[1]) s = S_P01;
    if (mask[0]) s = S_P00;
    return s;
  endfunction

  // State and sticky-done registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      sticky_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      sticky_q <= sticky_nxt;
    end
  end

  // Next-state logic.
  // Start is honoured only in IDLE.
  // The sticky flag is set by DONE and cleared when a start is accepted.
  always_comb begin
    state_nxt  = state;
    sticky_nxt = sticky_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = first_step(run_c & AFTER_IDLE);
          sticky_nxt = 1'b0;
        end
      end
      S_P00:   state_nxt = first_step(run_c & AFTER_P00);
      S_P01:   state_nxt = first_step(run_c & AFTER_P01);
      S_P10:   state_nxt = first_step(run_c & AFTER_P10);
      S_P11:   state_nxt = S_DONE;
      S_DONE: begin
        state_nxt  = S_IDLE;
        sticky_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode.
  // Outputs depend on state alone, except that IDLE also looks at start.
  // clr_prod is additionally gated by reset, so no clear is issued while
  // reset is asserted.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    shift_sel = 2'd0;
    upd_prod  = 1'b0;
    clr_prod  = 1'b0;
    case (state)
      S_IDLE: begin
        clr_prod = start & reset;
        done     = DONE_STICKY & sticky_q & ~start;
      end
      S_P00: begin
        busy     = 1'b1;
        upd_prod = 1'b1;
      end
      S_P01: begin
        busy      = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'd1;
        upd_prod  = 1'b1;
      end
      S_P10: begin
        busy      = 1'b1;
        a_sel     = 1'b1;
        shift_sel = 2'd1;
        upd_prod  = 1'b1;
      end
      S_P11: begin
        busy      = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'd2;
        upd_prod  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// tb_mult32x32_ctrl: bench for mult32x32_ctrl.
// It instantiates one pulse-done controller and one sticky-done controller,
// each driving a behavioural model of the arithmetic unit.
// Expected products and latencies go into a scoreboard when a start is
// accepted. They are popped and compared when done appears.
module tb_mult32x32_ctrl;

  localparam int unsigned MAX_WAIT = 12;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        start   = 1'b0;
  logic        start_s = 1'b0;
  logic [31:0] a       = '0;
  logic [31:0] b       = '0;

  logic       busy, done, a_sel, b_sel, upd_prod, clr_prod;
  logic [1:0] shift_sel;
  logic       busy_s, done_s, a_sel_s, b_sel_s, upd_prod_s, clr_prod_s;
  logic [1:0] shift_sel_s;

  logic [63:0] prod;
  logic [63:0] prod_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_p[$];
  int          sb_lat[$];

  mult32x32_ctrl #(.DONE_STICKY(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .a_sel(a_sel), .b_sel(b_sel),
    .shift_sel(shift_sel), .upd_prod(upd_prod), .clr_prod(clr_prod)
  );

  mult32x32_ctrl #(.DONE_STICKY(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .a(a), .b(b),
    .busy(busy_s), .done(done_s), .a_sel(a_sel_s), .b_sel(b_sel_s),
    .shift_sel(shift_sel_s), .upd_prod(upd_prod_s), .clr_prod(clr_prod_s)
  );

  always #5 clk = ~clk;

  // Partial product as the arithmetic unit forms it.
  function automatic logic [63:0] pp(input logic [31:0] x, input logic [31:0] y,
                                     input logic xs, input logic ys, input logic [1:0] sh);
    logic [15:0] xh;
    logic [15:0] yh;
    logic [63:0] p;
    xh = xs ? x[31:16] : x[15:0];
    yh = ys ? y[31:16] : y[15:0];
    p  = 64'(xh) * 64'(yh);
    case (sh)
      2'd0:    return p;
      2'd1:    return p << 16;
      default: return p << 32;
    endcase
  endfunction

  // Number of cycles from an accepted start to done.
  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef MULT_SKIP_ZERO_EN
    int n;
    logic [15:0] xh;
    logic [15:0] yh;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      xh = (i >= 2) ? x[31:16] : x[15:0];
      yh = (i % 2 == 1) ? y[31:16] : y[15:0];
      if (xh != 16'h0 && yh != 16'h0) n++;
    end
    return 1 + n;
`else
    return 5;
`endif
  endfunction

  // Arithmetic unit models: product register cleared by reset/clr_prod, accumulated on upd_prod.
  always @(posedge clk or negedge reset) begin
    if (!reset)        prod <= '0;
    else if (clr_prod) prod <= '0;
    else if (upd_prod) prod <= prod + pp(a, b, a_sel, b_sel, shift_sel);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset)          prod_s <= '0;
    else if (clr_prod_s) prod_s <= '0;
    else if (upd_prod_s) prod_s <= prod_s + pp(a, b, a_sel_s, b_sel_s, shift_sel_s);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle, drive the start inputs, then settle before sampling.
  task automatic next(input logic s, input logic ss = 1'b0);
    @(posedge clk);
    #1;
    start   = s;
    start_s = ss;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) next(1'b0);
    n_tests++;
    if ({busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod});
    end
    start = 1'b1;
    #1;
    n_tests++;
    if (clr_prod !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_held: got clr=%b busy=%b want 0 0", clr_prod, busy);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod, done_s, busy_s} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b want 0000000000",
               {busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod, done_s, busy_s});
    end
  endtask

  task automatic test_schedule();
    int   got_lat;
    logic ea;
    logic eb;
    logic [1:0] es;
    a = 32'h0001_0002;
    b = 32'h0003_0004;
    next(1'b1);
    n_tests++;
    if (clr_prod !== 1'b1 || busy !== 1'b0 || upd_prod !== 1'b0) begin
      n_fail++;
      $display("FAIL sched_accept: got clr=%b busy=%b upd=%b want 1 0 0", clr_prod, busy, upd_prod);
    end
    sb_p.push_back(64'h0000_0003_000A_0008);
    sb_lat.push_back(exp_lat(a, b));
    got_lat = 0;
    for (int k = 1; k <= int'(MAX_WAIT); k++) begin
      next(1'b0);
      if (k <= 4) begin
        ea = (k >= 3);
        eb = (k == 2 || k == 4);
        es = (k == 1) ? 2'd0 : ((k == 4) ? 2'd2 : 2'd1);
        n_tests++;
        if ({busy, a_sel, b_sel, shift_sel, upd_prod, clr_prod, done} !== {1'b1, ea, eb, es, 3'b100}) begin
          n_fail++;
          $display("FAIL sched_step%0d: got %b want %b", k,
                   {busy, a_sel, b_sel, shift_sel, upd_prod, clr_prod, done}, {1'b1, ea, eb, es, 3'b100});
        end
      end
      if (done === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    n_tests++;
    if (got_lat != sb_lat[0]) begin
      n_fail++;
      $display("FAIL sched_latency: got %0d want %0d", got_lat, sb_lat[0]);
    end
    n_tests++;
    if (prod !== sb_p[0] || busy !== 1'b0 || upd_prod !== 1'b0) begin
      n_fail++;
      $display("FAIL sched_product: got %h busy=%b upd=%b want %h 0 0", prod, busy, upd_prod, sb_p[0]);
    end
    void'(sb_p.pop_front());
    void'(sb_lat.pop_front());
    next(1'b0);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL sched_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_ones();
    int got_lat;
    int upd_n;
    int late_upd;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    next(1'b1);
    sb_p.push_back(64'hFFFF_FFFE_0000_0001);
    sb_lat.push_back(exp_lat(a, b));
    got_lat = 0;
    upd_n   = 0;
    for (int k = 1; k <= int'(MAX_WAIT); k++) begin
      next(1'b0);
      if (upd_prod === 1'b1) upd_n++;
      if (done === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    n_tests++;
    if (got_lat != sb_lat[0] || prod !== sb_p[0]) begin
      n_fail++;
      $display("FAIL ones_result: got lat=%0d prod=%h want lat=%0d prod=%h", got_lat, prod, sb_lat[0], sb_p[0]);
    end
    void'(sb_p.pop_front());
    void'(sb_lat.pop_front());
    late_upd = 0;
    repeat (2) begin
      next(1'b0);
      if (upd_prod !== 1'b0) late_upd++;
    end
    n_tests++;
    if (upd_n != 4 || late_upd != 0) begin
      n_fail++;
      $display("FAIL ones_upd_count: got %0d/%0d want 4/0", upd_n, late_upd);
    end
  endtask

  task automatic test_ignore_start();
    int upd_n;
    int clr_n;
    int done_n;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    next(1'b1);
    sb_p.push_back(64'(a) * 64'(b));
    sb_lat.push_back(exp_lat(a, b));
    upd_n  = 0;
    clr_n  = 0;
    done_n = 0;
    for (int k = 1; k <= 8; k++) begin
      next((k == 2 || k == 5) ? 1'b1 : 1'b0);
      if (upd_prod === 1'b1) upd_n++;
      if (clr_prod === 1'b1) clr_n++;
      if (done === 1'b1) begin
        done_n++;
        n_tests++;
        if (k != sb_lat[0] || prod !== sb_p[0]) begin
          n_fail++;
          $display("FAIL ignore_result: got cyc=%0d prod=%h want cyc=%0d prod=%h", k, prod, sb_lat[0], sb_p[0]);
        end
        void'(sb_p.pop_front());
        void'(sb_lat.pop_front());
      end
    end
    n_tests++;
    if (upd_n != 4 || clr_n != 0 || done_n != 1) begin
      n_fail++;
      $display("FAIL ignore_counts: got upd=%0d clr=%0d done=%0d want 4 0 1", upd_n, clr_n, done_n);
    end
  endtask

  task automatic test_back_to_back();
    int last_acc;
    int clr_n;
    int clr_at;
    int done_n;
    a = 32'h89AB_CDEF;
    b = 32'h7654_3210;
    next(1'b1);
    n_tests++;
    if (clr_prod !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept0: got %b want 1", clr_prod);
    end
    repeat (2) begin
      sb_p.push_back(64'(a) * 64'(b));
      sb_lat.push_back(exp_lat(a, b));
    end
    last_acc = 0;
    clr_n    = 0;
    clr_at   = -1;
    done_n   = 0;
    for (int k = 1; k <= 12; k++) begin
      next((k <= 6) ? 1'b1 : 1'b0);
      if (clr_prod === 1'b1) begin
        clr_n++;
        clr_at   = k;
        last_acc = k;
      end
      if (done === 1'b1) begin
        done_n++;
        n_tests++;
        if (sb_p.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_done: got done at cycle %0d want none", k);
        end else begin
          if ((k - last_acc) != sb_lat[0] || prod !== sb_p[0]) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got lat=%0d prod=%h want lat=%0d prod=%h",
                     done_n, k - last_acc, prod, sb_lat[0], sb_p[0]);
          end
          void'(sb_p.pop_front());
          void'(sb_lat.pop_front());
        end
      end
    end
    n_tests++;
    if (clr_n != 1 || clr_at != 6 || done_n != 2) begin
      n_fail++;
      $display("FAIL b2b_restart: got clr_n=%0d clr_at=%0d done_n=%0d want 1 6 2", clr_n, clr_at, done_n);
    end
  endtask

  task automatic test_reset_mid();
    int got_lat;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    next(1'b1);
    sb_p.push_back(64'(a) * 64'(b));
    sb_lat.push_back(exp_lat(a, b));
    next(1'b0);
    next(1'b0);
    n_tests++;
    if (busy !== 1'b1 || b_sel !== 1'b1 || a_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_in_p01: got busy=%b a=%b b=%b want 1 0 1", busy, a_sel, b_sel);
    end
    reset = 1'b0;
    #1;
    sb_p.delete();
    sb_lat.delete();
    n_tests++;
    if ({busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod} !== 8'h00 || prod !== 64'h0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got %b prod=%h want 00000000 prod=0",
               {busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod}, prod);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    next(1'b0);
    n_tests++;
    if ({busy, done, upd_prod, clr_prod} !== 4'h0) begin
      n_fail++;
      $display("FAIL rstmid_idle: got %b want 0000", {busy, done, upd_prod, clr_prod});
    end
    next(1'b1);
    sb_p.push_back(64'(a) * 64'(b));
    sb_lat.push_back(exp_lat(a, b));
    got_lat = 0;
    for (int k = 1; k <= int'(MAX_WAIT); k++) begin
      next(1'b0);
      if (done === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    n_tests++;
    if (got_lat != sb_lat[0] || prod !== sb_p[0]) begin
      n_fail++;
      $display("FAIL rstmid_rerun: got lat=%0d prod=%h want lat=%0d prod=%h", got_lat, prod, sb_lat[0], sb_p[0]);
    end
    void'(sb_p.pop_front());
    void'(sb_lat.pop_front());
    next(1'b0);
  endtask

  task automatic test_skip_zero();
    logic [31:0] av[2];
    logic [31:0] bv[2];
    int got_lat;
    int upd_n;
    av[0] = 32'h0000_0005;
    bv[0] = 32'h0000_0007;
    av[1] = 32'h0000_0000;
    bv[1] = 32'h0000_1234;
    for (int t = 0; t < 2; t++) begin
      a = av[t];
      b = bv[t];
      next(1'b1);
      sb_p.push_back(64'(a) * 64'(b));
      sb_lat.push_back(exp_lat(a, b));
      got_lat = 0;
      upd_n   = 0;
      for (int k = 1; k <= int'(MAX_WAIT); k++) begin
        next(1'b0);
        if (upd_prod === 1'b1) upd_n++;
        if (done === 1'b1) begin
          got_lat = k;
          break;
        end
      end
      n_tests++;
      if (got_lat != sb_lat[0] || prod !== sb_p[0] || upd_n != sb_lat[0] - 1) begin
        n_fail++;
        $display("FAIL skip_op%0d: got lat=%0d prod=%h upd=%0d want lat=%0d prod=%h upd=%0d",
                 t, got_lat, prod, upd_n, sb_lat[0], sb_p[0], sb_lat[0] - 1);
      end
      void'(sb_p.pop_front());
      void'(sb_lat.pop_front());
      next(1'b0);
    end
  endtask

  task automatic test_sticky();
    int got_lat;
    int held;
    a = 32'h0001_0002;
    b = 32'h0003_0004;
    next(1'b0, 1'b1);
    sb_p.push_back(64'h0000_0003_000A_0008);
    sb_lat.push_back(exp_lat(a, b));
    got_lat = 0;
    for (int k = 1; k <= int'(MAX_WAIT); k++) begin
      next(1'b0, 1'b0);
      if (done_s === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    n_tests++;
    if (got_lat != sb_lat[0] || prod_s !== sb_p[0]) begin
      n_fail++;
      $display("FAIL sticky_result: got lat=%0d prod=%h want lat=%0d prod=%h", got_lat, prod_s, sb_lat[0], sb_p[0]);
    end
    void'(sb_p.pop_front());
    void'(sb_lat.pop_front());
    held = 0;
    for (int k = 0; k < 10; k++) begin
      next(1'b0, 1'b0);
      if (done_s === 1'b1 && busy_s === 1'b0) held++;
    end
    n_tests++;
    if (held != 10 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_hold: got held=%0d pulse_done=%b want 10 0", held, done);
    end
    next(1'b0, 1'b1);
    n_tests++;
    if (clr_prod_s !== 1'b1 || done_s !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_drop: got clr=%b done=%b want 1 0", clr_prod_s, done_s);
    end
    next(1'b0, 1'b0);
    n_tests++;
    if (done_s !== 1'b0 || busy_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_next_op: got done=%b busy=%b want 0 1", done_s, busy_s);
    end
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_ones();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_skip_zero();
    test_sticky();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
